ls_quad_pipe: RTL and testbench
===============================

Name: ls_quad_pipe

Overview:
Parametrised successor to the current SPU local store: a single-ported quadword local store behind a fixed-latency load/store pipe. Decodes the A-form, instruction-relative, D-form (and, optionally, X-form) quadword load/store opcodes, computes and aligns the effective address, and commits stores. Returns load data to the forwarding/writeback network after LATENCY cycles as a tagged result packet. Adds capabilities the current unit lacks: sized store, configurable latency, valid qualification, pipeline flush, and a fixed per-cycle result position.

Parameters:
LS_BYTES, 262144, local store size in bytes; power of two, >= 16; memory depth = LS_BYTES/16 quadwords.
LATENCY, 6, issue-to-result cycles; legal range 2..8.
PC_W, 32, width of PCin.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset; reset=0 clears the pipe immediately.
in_valid  in  1  request present this cycle.
opcode9  in  9  A-form/relative opcode field.
opcode8  in  8  D-form opcode field.
opcode11  in  11  X-form opcode field; ignored unless LS_XFORM_EN is defined.
ra  in  128  ra register value; word0 = ra[0:31] is the base.
rb  in  128  rb register value; word0 used by X-form only.
rt  in  128  store data.
addr_rt  in  7  destination register of a load.
immediate16  in  16  I16 field.
immediate10  in  10  I10 field.
PCin  in  PC_W  address of the instruction being issued.
flush  in  1  kill every in-flight result and the current request.
fw_valid  out  1  result packet valid.
fw_data  out  128  load data, big-endian [0:127].
fw_rt  out  7  destination register.
fw_wr  out  1  register write enable; 1 only for loads.
illegal  out  1  pulses 1 cycle after an in_valid request with no matching opcode.

Behaviour:
- Decode, priority order: opcode9, then opcode8, then opcode11.
  - lqa: opcode9 = 001100001.
  - lqr: opcode9 = 001100111.
  - stqa: opcode9 = 001000001.
  - stqr: opcode9 = 001000111.
  - lqd: opcode8 = 00110100.
  - stqd: opcode8 = 00100100.
  - lqx: opcode11 = 00111000100.
  - stqx: opcode11 = 00101000100.
- Effective address (32-bit arithmetic, wraps silently):
  - A-form: sext(I16) << 2.
  - Relative: PCin + (sext(I16) << 2).
  - D-form: ra word0 + (sext(I10) << 4).
  - X-form: ra word0 + rb word0.
- Final address = EA & (LS_BYTES-1) & ~0xF. Low 4 bits are ignored; out-of-range addresses wrap modulo LS_BYTES.
- Store: rt is written to mem[addr>>4] at the issue clock edge. No result packet is produced (fw_valid stays 0 for that slot).
- Load: mem[addr>>4] is read at the issue edge; the result appears on the fw_* outputs exactly LATENCY cycles after issue.
  - Example: request at edge n, fw_valid=1 during cycle n+LATENCY.
- Fully pipelined, one request per cycle, no stall.
- Read-after-write ordering:
  - A load issued any cycle after a store to the same quadword returns the new data.
  - Only one request per cycle, so there is no same-cycle conflict.
- flush=1 at an edge:
  - Clears all stage valids.
  - Drops the request on that edge: a store is not written, a load is not enqueued.
  - fw_valid is 0 for the next LATENCY cycles, except for requests issued after the flush.
- Unmatched opcode with in_valid=1: no memory access, illegal=1 for one cycle, no fw packet.
- Reset (reset=0, async):
  - Clears fw_valid, fw_wr, illegal, fw_rt and fw_data to 0, and all stage valids.
  - Memory contents are not reset.
  - Requests are ignored while reset=0.
  - Reset mid-operation discards in-flight loads and any pending illegal pulse.
- Stage data registers enable only on valid, so fw_data holds its last value when fw_valid=0.

Optional Feature:
LS_XFORM_EN:
- Defined: lqx/stqx are decoded from opcode11.
- Undefined: opcode11 is ignored, and an X-form request with no opcode9/opcode8 match raises illegal.

Test Plan:
- Reset and first store/load: hold reset=0 for 2 cycles, release. Issue stqa with I16=4, rt=0x3727C5AC_612D78EC_501502F9_00000000, then lqa with I16=4, addr_rt=9. Expect fw_valid=1, fw_rt=9, fw_wr=1 and fw_data equal to rt, exactly LATENCY cycles after the lqa; no fw packet for the store.
- D-form and relative addressing: with ra word0=0x100, stqd I10=1 writes addr 0x110. With PCin=0x100, lqr I16=4 (EA=0x110) returns the same data.
- Address wrap with LS_BYTES=4096: lqd with ra word0=0x0FF8, I10=1 (EA=0x1008) must read quadword 0x000 (0x1008 mod 4096 = 0x008, aligned down).
- Back-to-back pipelining: 6 consecutive loads to addrs 0x0..0x50 with addr_rt 0..5. Expect 6 consecutive fw_valid cycles, fw_rt 0..5 in order.
- Flush: issue 3 loads, assert flush on the 4th edge together with a stqa. Expect no fw_valid for the 3 loads and the stored address unchanged on re-read.
- Illegal and reset mid-operation:
  - opcode9=0, opcode8=0 with in_valid=1 gives illegal=1 for one cycle.
  - Pulse reset=0 while 2 loads are in flight: fw_valid=0 immediately, and the 2 loads never appear.
  - With LS_XFORM_EN defined, stqx/lqx with ra=0x20, rb=0x10 round-trip at 0x30.

Source files
------------

// File: rtl/ls_quad_pipe.sv
// ls_quad_pipe: single-ported quadword local store behind a fixed-latency
// load/store pipe. Decodes A-form, relative and D-form quadword loads/stores,
// forms and aligns the effective address, commits stores at the issue edge,
// and returns load data as a tagged packet LATENCY cycles after issue.
// Optional X-form (lqx/stqx) decode is enabled by defining LS_XFORM_EN.
// Parameters: LS_BYTES (power of two, >= 16), LATENCY (2..8), PC_W.
module ls_quad_pipe #(
    parameter int LS_BYTES = 262144,
    parameter int LATENCY  = 6,
    parameter int PC_W     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [8:0]      opcode9,
    input  logic [7:0]      opcode8,
    input  logic [10:0]     opcode11,
    input  logic [0:127]    ra,
    input  logic [0:127]    rb,
    input  logic [0:127]    rt,
    input  logic [6:0]      addr_rt,
    input  logic [15:0]     immediate16,
    input  logic [9:0]      immediate10,
    input  logic [PC_W-1:0] PCin,
    input  logic            flush,
    output logic            fw_valid,
    output logic [0:127]    fw_data,
    output logic [6:0]      fw_rt,
    output logic            fw_wr,
    output logic            illegal
);

    // Local store geometry: one entry per 16-byte quadword.
    localparam int DEPTH = LS_BYTES / 16;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] QW_MASK = 32'(DEPTH - 1);

    // Opcode encodings.
    localparam logic [8:0]  OP_LQA  = 9'b001100001;
    localparam logic [8:0]  OP_LQR  = 9'b001100111;
    localparam logic [8:0]  OP_STQA = 9'b001000001;
    localparam logic [8:0]  OP_STQR = 9'b001000111;
    localparam logic [7:0]  OP_LQD  = 8'b00110100;
    localparam logic [7:0]  OP_STQD = 8'b00100100;
`ifdef LS_XFORM_EN
    localparam logic [10:0] OP_LQX  = 11'b00111000100;
    localparam logic [10:0] OP_STQX = 11'b00101000100;
`endif

    typedef enum logic [1:0] {
        MODE_A   = 2'd0,
        MODE_REL = 2'd1,
        MODE_D   = 2'd2,
        MODE_X   = 2'd3
    } addr_mode_t;

    // Decode results.
    addr_mode_t         mode;
    logic               hit;
    logic               is_load;

    // Address path.
    logic [31:0]        pc32;
    logic [31:0]        i16_ext;
    logic [31:0]        i10_ext;
    logic [31:0]        ea;
    logic [IDX_W-1:0]   idx;

    // Request qualification.
    logic               req_ok;
    logic               load_go;
    logic               store_go;
    logic               illegal_next;

    // Storage and pipe.
    logic [0:127]       mem [0:DEPTH-1];
    logic [0:127]       rd_data;
    logic [LATENCY:1]   stage_valid;
    logic [6:0]         stage_rt   [1:LATENCY];
    logic [0:127]       stage_data [2:LATENCY];

    // Bits of the operand registers the address path never looks at.
    logic               unused_bits;

    // Decode with opcode9 taking priority over opcode8, then opcode11.
    always_comb begin
        hit     = 1'b0;
        is_load = 1'b0;
        mode    = MODE_A;
        if (opcode9 == OP_LQA) begin
            hit = 1'b1; is_load = 1'b1; mode = MODE_A;
        end else if (opcode9 == OP_LQR) begin
            hit = 1'b1; is_load = 1'b1; mode = MODE_REL;
        end else if (opcode9 == OP_STQA) begin
            hit = 1'b1; is_load = 1'b0; mode = MODE_A;
        end else if (opcode9 == OP_STQR) begin
            hit = 1'b1; is_load = 1'b0; mode = MODE_REL;
        end else if (opcode8 == OP_LQD) begin
            hit = 1'b1; is_load = 1'b1; mode = MODE_D;
        end else if (opcode8 == OP_STQD) begin
            hit = 1'b1; is_load = 1'b0; mode = MODE_D;
        end
`ifdef LS_XFORM_EN
        else if (opcode11 == OP_LQX) begin
            hit = 1'b1; is_load = 1'b1; mode = MODE_X;
        end else if (opcode11 == OP_STQX) begin
            hit = 1'b1; is_load = 1'b0; mode = MODE_X;
        end
`endif
    end

    // Effective address in 32-bit wrapping arithmetic, then quadword index
    // wrapped modulo the store size (low four byte-offset bits dropped).
    always_comb begin
        pc32    = 32'(PCin);
        i16_ext = {{14{immediate16[15]}}, immediate16, 2'b00};
        i10_ext = {{18{immediate10[9]}}, immediate10, 4'b0000};
        ea      = i16_ext;
        case (mode)
            MODE_A:   ea = i16_ext;
            MODE_REL: ea = pc32 + i16_ext;
            MODE_D:   ea = ra[0:31] + i10_ext;
            MODE_X:   ea = ra[0:31] + rb[0:31];
            default:  ea = i16_ext;
        endcase
        idx = IDX_W'((ea >> 4) & QW_MASK);
    end

    // A flushed request is dropped entirely: no write, no load, no illegal.
    always_comb begin
        req_ok       = in_valid && !flush;
        load_go      = req_ok && hit && is_load;
        store_go     = req_ok && hit && !is_load;
        illegal_next = req_ok && !hit;
    end

    // Single-ported store: write or read at the issue edge; contents survive
    // reset, but nothing is accessed while reset is asserted (low).
    always_ff @(posedge clk) begin
        if (reset) begin
            if (store_go) begin
                mem[idx] <= rt;
            end
            if (load_go) begin
                rd_data <= mem[idx];
            end
        end
    end

    // Result pipe: stage 1 is loaded at the issue edge and stage LATENCY
    // drives fw_*; data/tag registers only advance behind a valid load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_valid <= '0;
            for (int i = 1; i <= LATENCY; i++) begin
                stage_rt[i] <= '0;
            end
            for (int i = 2; i <= LATENCY; i++) begin
                stage_data[i] <= '0;
            end
        end else begin
            if (flush) begin
                stage_valid <= '0;
            end else begin
                stage_valid <= {stage_valid[LATENCY-1:1], load_go};
            end
            if (load_go) begin
                stage_rt[1] <= addr_rt;
            end
            if (stage_valid[1] && !flush) begin
                stage_rt[2]   <= stage_rt[1];
                stage_data[2] <= rd_data;
            end
            for (int i = 3; i <= LATENCY; i++) begin
                if (stage_valid[i-1] && !flush) begin
                    stage_rt[i]   <= stage_rt[i-1];
                    stage_data[i] <= stage_data[i-1];
                end
            end
        end
    end

    // One-cycle illegal pulse for an unmatched, unflushed request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal <= 1'b0;
        end else begin
            illegal <= illegal_next;
        end
    end

    // Only loads ever reach the last stage, so the write enable tracks valid.
    assign fw_valid = stage_valid[LATENCY];
    assign fw_wr    = stage_valid[LATENCY];
    assign fw_rt    = stage_rt[LATENCY];
    assign fw_data  = stage_data[LATENCY];

`ifdef LS_XFORM_EN
    assign unused_bits = ^{ra[32:127], rb[32:127], ea[3:0]};
`else
    assign unused_bits = ^{ra[32:127], rb[32:127], ea[3:0], opcode11};
`endif

endmodule

// File: tb/tb_ls_quad_pipe.sv
// tb_ls_quad_pipe: table-driven vectors plus hand sequences for pipelining,
// flush and mid-operation reset, with a scoreboard of expected packets.
module tb_ls_quad_pipe;

    localparam int LS_BYTES = 4096;
    localparam int LATENCY  = 6;
    localparam int PC_W     = 32;

    typedef enum logic [3:0] {
        K_STQA, K_LQA, K_STQR, K_LQR, K_STQD, K_LQD, K_STQX, K_LQX, K_BAD
    } kind_t;

    typedef struct {
        kind_t        kind;
        logic [15:0]  i16;
        logic [9:0]   i10;
        logic [31:0]  ra0;
        logic [31:0]  rb0;
        logic [31:0]  pc;
        logic [127:0] data;
        logic [6:0]   dst;
        logic [31:0]  exp_addr;
    } vec_t;

    typedef struct {
        int           due;
        logic [6:0]   dst;
        logic [127:0] data;
    } exp_t;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic [8:0]      opcode9;
    logic [7:0]      opcode8;
    logic [10:0]     opcode11;
    logic [0:127]    ra;
    logic [0:127]    rb;
    logic [0:127]    rt;
    logic [6:0]      addr_rt;
    logic [15:0]     immediate16;
    logic [9:0]      immediate10;
    logic [PC_W-1:0] PCin;
    logic            flush;
    logic            fw_valid;
    logic [0:127]    fw_data;
    logic [6:0]      fw_rt;
    logic            fw_wr;
    logic            illegal;

    int              n_checks = 0;
    int              n_fail   = 0;
    int              now      = 0;
    int              ill_due  = -1;
    exp_t            sb[$];
    logic [127:0]    model [int];
    vec_t            tbl[$];

    ls_quad_pipe #(
        .LS_BYTES (LS_BYTES),
        .LATENCY  (LATENCY),
        .PC_W     (PC_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .opcode9     (opcode9),
        .opcode8     (opcode8),
        .opcode11    (opcode11),
        .ra          (ra),
        .rb          (rb),
        .rt          (rt),
        .addr_rt     (addr_rt),
        .immediate16 (immediate16),
        .immediate10 (immediate10),
        .PCin        (PCin),
        .flush       (flush),
        .fw_valid    (fw_valid),
        .fw_data     (fw_data),
        .fw_rt       (fw_rt),
        .fw_wr       (fw_wr),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (tick %0d)", name, act, exp, now);
        end
    endtask

    function automatic vec_t mk(input kind_t k, input logic [15:0] i16, input logic [9:0] i10,
                                input logic [31:0] ra0, input logic [31:0] rb0, input logic [31:0] pc,
                                input logic [127:0] data, input logic [6:0] dst, input logic [31:0] exp_addr);
        vec_t v;
        v.kind = k; v.i16 = i16; v.i10 = i10; v.ra0 = ra0; v.rb0 = rb0; v.pc = pc;
        v.data = data; v.dst = dst; v.exp_addr = exp_addr;
        return v;
    endfunction

    // Compare outputs against the scoreboard head and the pending illegal pulse.
    task automatic checkOutput();
        exp_t e;
        if (sb.size() > 0 && sb[0].due == now) begin
            e = sb.pop_front();
            check("fw_valid", 128'(fw_valid), 128'd1);
            check("fw_wr", 128'(fw_wr), 128'd1);
            check("fw_rt", 128'(fw_rt), 128'(e.dst));
            check("fw_data", fw_data, e.data);
        end else begin
            check("fw_valid_idle", 128'(fw_valid), 128'd0);
            check("fw_wr_idle", 128'(fw_wr), 128'd0);
        end
        check("illegal", 128'(illegal), 128'(ill_due == now));
    endtask

    task automatic tick();
        @(negedge clk);
        now++;
        checkOutput();
    endtask

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0;
        opcode9 = '0; opcode8 = '0; opcode11 = '0;
    endtask

    // Drive one request and record its expected effect (skipped if flushed).
    task automatic applyStimulus(input vec_t v, input bit with_flush);
        int idx;
        bit legal;
        bit load;
        idx = int'(v.exp_addr >> 4);
        in_valid = 1'b1; flush = with_flush;
        opcode9 = '0; opcode8 = '0; opcode11 = '0;
        immediate16 = v.i16; immediate10 = v.i10;
        ra = {v.ra0, 96'hDEADBEEF_0BADF00D_13579BDF};
        rb = {v.rb0, 96'hFEEDFACE_2468ACE0_C0FFEE00};
        rt = v.data; PCin = v.pc; addr_rt = v.dst;
        legal = 1'b1; load = 1'b0;
        case (v.kind)
            K_STQA: opcode9 = 9'b001000001;
            K_LQA:  begin opcode9 = 9'b001100001; load = 1'b1; end
            K_STQR: opcode9 = 9'b001000111;
            K_LQR:  begin opcode9 = 9'b001100111; load = 1'b1; end
            K_STQD: opcode8 = 8'b00100100;
            K_LQD:  begin opcode8 = 8'b00110100; load = 1'b1; end
            K_STQX: opcode11 = 11'b00101000100;
            K_LQX:  begin opcode11 = 11'b00111000100; load = 1'b1; end
            default: legal = 1'b0;
        endcase
`ifndef LS_XFORM_EN
        if (v.kind == K_STQX || v.kind == K_LQX) legal = 1'b0;
`endif
        if (with_flush) begin
            while (sb.size() > 0 && sb[sb.size()-1].due > now) void'(sb.pop_back());
            if (ill_due > now) ill_due = -1;
        end else if (!legal) begin
            ill_due = now + 1;
        end else if (load) begin
            sb.push_back('{due: now + LATENCY, dst: v.dst, data: model[idx]});
        end else begin
            model[idx] = v.data;
        end
    endtask

    initial begin
        $display("[TB] start LS_BYTES=%0d LATENCY=%0d", LS_BYTES, LATENCY);
        idle();
        ra = '0; rb = '0; rt = '0; addr_rt = '0;
        immediate16 = '0; immediate10 = '0; PCin = '0;
        reset = 1'b0;

        // Reset state after two cycles held low.
        tick(); tick();
        check("rst_fw_valid", 128'(fw_valid), 128'd0);
        check("rst_fw_wr", 128'(fw_wr), 128'd0);
        check("rst_illegal", 128'(illegal), 128'd0);
        check("rst_fw_rt", 128'(fw_rt), 128'd0);
        check("rst_fw_data", fw_data, 128'd0);
        reset = 1'b1;
        tick();

        // Vector table: kind, i16, i10, ra0, rb0, pc, data, dst, expected aligned address.
        tbl.push_back(mk(K_STQA, 16'h0004, 10'h000, 32'h0, 32'h0, 32'h0, 128'h3727C5AC_612D78EC_501502F9_00000000, 7'd0, 32'h010));
        tbl.push_back(mk(K_LQA,  16'h0004, 10'h000, 32'h0, 32'h0, 32'h0, 128'h0, 7'd9, 32'h010));
        tbl.push_back(mk(K_STQD, 16'h0000, 10'h001, 32'h100, 32'h0, 32'h0, 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0, 7'd0, 32'h110));
        tbl.push_back(mk(K_LQR,  16'h0004, 10'h000, 32'h0, 32'h0, 32'h100, 128'h0, 7'd3, 32'h110));
        tbl.push_back(mk(K_LQD,  16'h0000, 10'h000, 32'h11F, 32'h0, 32'h0, 128'h0, 7'd8, 32'h110));
        tbl.push_back(mk(K_STQA, 16'h0000, 10'h000, 32'h0, 32'h0, 32'h0, 128'h00000000_11111111_22222222_33333333, 7'd0, 32'h000));
        tbl.push_back(mk(K_LQD,  16'h0000, 10'h001, 32'h0FF8, 32'h0, 32'h0, 128'h0, 7'd4, 32'h000));
        tbl.push_back(mk(K_STQR, 16'hFFFC, 10'h000, 32'h0, 32'h0, 32'h200, 128'hCAFEF00D_DEADBEEF_0BADC0DE_FEEDFACE, 7'd0, 32'h1F0));
        tbl.push_back(mk(K_LQA,  16'h007C, 10'h000, 32'h0, 32'h0, 32'h0, 128'h0, 7'd5, 32'h1F0));
        tbl.push_back(mk(K_STQD, 16'h0000, 10'h3FF, 32'h5, 32'h0, 32'h0, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 7'd0, 32'hFF0));
        tbl.push_back(mk(K_LQA,  16'hFFFC, 10'h000, 32'h0, 32'h0, 32'h0, 128'h0, 7'd6, 32'hFF0));
        tbl.push_back(mk(K_BAD,  16'h0000, 10'h000, 32'h0, 32'h0, 32'h0, 128'h0, 7'd0, 32'h000));
        tbl.push_back(mk(K_STQX, 16'h0000, 10'h000, 32'h20, 32'h10, 32'h0, 128'h5555AAAA_AAAA5555_F0F0F0F0_0F0F0F0F, 7'd0, 32'h030));
        tbl.push_back(mk(K_LQX,  16'h0000, 10'h000, 32'h20, 32'h10, 32'h0, 128'h0, 7'd7, 32'h030));
        tbl.push_back(mk(K_LQR,  16'h0004, 10'h000, 32'h0, 32'h0, 32'h10000100, 128'h0, 7'd10, 32'h110));
        foreach (tbl[i]) begin
            applyStimulus(tbl[i], 1'b0);
            tick();
        end
        idle();
        repeat (LATENCY + 1) tick();

        // Back-to-back: six stores, then six consecutive loads with tags 0..5.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(mk(K_STQA, 16'(4 * i), 10'h0, 32'h0, 32'h0, 32'h0,
                             {4{32'hB0B00000 + 32'(i)}}, 7'd0, 32'(16 * i)), 1'b0);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(mk(K_LQA, 16'(4 * i), 10'h0, 32'h0, 32'h0, 32'h0,
                             128'h0, 7'(i), 32'(16 * i)), 1'b0);
            tick();
        end
        idle();
        repeat (LATENCY + 1) tick();

        // Flush: three loads in flight, flush arrives with a store to 0x10.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk(K_LQA, 16'(4 * i), 10'h0, 32'h0, 32'h0, 32'h0,
                             128'h0, 7'(20 + i), 32'(16 * i)), 1'b0);
            tick();
        end
        applyStimulus(mk(K_STQA, 16'h0004, 10'h0, 32'h0, 32'h0, 32'h0,
                         128'hFFFFFFFF_00000000_FFFFFFFF_00000000, 7'd0, 32'h010), 1'b1);
        tick();
        idle();
        repeat (LATENCY + 1) tick();
        applyStimulus(mk(K_LQA, 16'h0004, 10'h0, 32'h0, 32'h0, 32'h0, 128'h0, 7'd11, 32'h010), 1'b0);
        tick();
        idle();
        repeat (LATENCY + 1) tick();

        // Reset mid-operation: two loads in flight and an illegal pulse showing.
        applyStimulus(mk(K_LQA, 16'h0000, 10'h0, 32'h0, 32'h0, 32'h0, 128'h0, 7'd12, 32'h000), 1'b0);
        tick();
        applyStimulus(mk(K_LQA, 16'h0004, 10'h0, 32'h0, 32'h0, 32'h0, 128'h0, 7'd13, 32'h010), 1'b0);
        tick();
        applyStimulus(mk(K_BAD, 16'h0, 10'h0, 32'h0, 32'h0, 32'h0, 128'h0, 7'd0, 32'h0), 1'b0);
        tick();
        idle();
        #2;
        reset = 1'b0;
        #1;
        check("midrst_fw_valid", 128'(fw_valid), 128'd0);
        check("midrst_fw_wr", 128'(fw_wr), 128'd0);
        check("midrst_illegal", 128'(illegal), 128'd0);
        check("midrst_fw_rt", 128'(fw_rt), 128'd0);
        check("midrst_fw_data", fw_data, 128'd0);
        sb.delete();
        ill_due = -1;
        // A store presented during reset must be ignored.
        in_valid = 1'b1; opcode9 = 9'b001000001; immediate16 = 16'h0004;
        rt = 128'h12121212_34343434_56565656_78787878;
        tick(); tick();
        idle();
        reset = 1'b1;
        repeat (LATENCY + 2) tick();
        applyStimulus(mk(K_LQA, 16'h0004, 10'h0, 32'h0, 32'h0, 32'h0, 128'h0, 7'd14, 32'h010), 1'b0);
        tick();
        idle();
        repeat (LATENCY + 1) tick();

        check("sb_drain", 128'(sb.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
